// File: rtl/rf_dump_reader.sv
// Debug register-file dump engine: halts the pipeline, walks registers
// FIRST_REG..LAST_REG through read port 1 and streams (index, value) beats
// over a valid/ready interface.
module rf_dump_reader #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        halt_ack,
  output logic        halt_req,
  output logic        rd_sel,
  output logic [3:0]  rd_reg,
  input  logic [15:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [3:0]  out_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] FIRST_IDX = 4'(FIRST_REG);
  localparam logic [3:0] LAST_IDX  = 4'(LAST_REG);

  typedef enum logic [2:0] {IDLE, HALT, READ, SEND, DONE} state_t;

  state_t     state, state_next;
  logic [3:0] idx, idx_next;

  // Next-state and next-index selection; abort outranks out_ready.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = HALT;
          idx_next   = FIRST_IDX;
        end
      end
      HALT: begin
        if (abort)         state_next = IDLE;
        else if (halt_ack) state_next = READ;
      end
      READ: begin
        state_next = abort ? IDLE : SEND;
      end
      SEND: begin
        if (abort) begin
          state_next = IDLE;
        end else if (out_ready) begin
          // Compare before incrementing so LAST_REG=15 never wraps idx.
          if (idx == LAST_IDX) begin
            state_next = DONE;
          end else begin
            state_next = READ;
            idx_next   = idx + 4'd1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, index and read-port register; rd_reg is loaded only on entry
  // to READ so it holds its last value everywhere else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= FIRST_IDX;
      rd_reg <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (state_next == READ && state != READ) rd_reg <= idx_next;
    end
  end

  // Capture the read-port value while this block owns the mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_idx  <= '0;
    end else if (state == READ) begin
      out_data <= rd_data;
      out_idx  <= idx;
    end
  end

  // Control outputs decoded purely from the state register.
  always_comb begin
    halt_req  = 1'b0;
    rd_sel    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE:    busy = 1'b0;
      HALT:    halt_req = 1'b1;
      READ:    begin halt_req = 1'b1; rd_sel = 1'b1; end
      SEND:    begin halt_req = 1'b1; out_valid = 1'b1; end
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: doc/rf_dump_reader.md
Name: rf_dump_reader

Overview:
- Debug read-out engine and read-side initiator for the 16x16 register file.
- On request, it stalls the pipeline, walks registers FIRST_REG..LAST_REG through one register-file read port, and streams each value with its index over a valid/ready interface. The consumer is typically a debug UART or a trace buffer.
- It sits beside the decode stage and borrows read port 1 while the pipeline is halted.

Parameters:
FIRST_REG, 0, first register index dumped (0..15)
LAST_REG, 15, last register index dumped (FIRST_REG..15)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle dump request; ignored unless in IDLE
abort  input  1  cancel an in-progress dump
halt_ack  input  1  pipeline confirms it is stalled and the read port is free
halt_req  output  1  request pipeline stall
rd_sel  output  1  1 = this block owns the read-port mux
rd_reg  output  4  register ID driven to the read port
rd_data  input  16  combinational read data for rd_reg (same cycle)
out_valid  output  1  out_data/out_idx valid
out_ready  input  1  consumer accepts the beat
out_data  output  16  captured register value
out_idx  output  4  index of out_data
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high; it forces state=IDLE, idx=FIRST_REG, and all outputs to 0 (rd_reg=0, out_data=0, out_idx=0).
- All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.
- FSM states: IDLE, HALT, READ, SEND, DONE.
- IDLE: on start=1, go to HALT and set idx=FIRST_REG.
- HALT: halt_req=1. When halt_ack=1, go to READ. There is no timeout.
- READ: halt_req=1, rd_sel=1, rd_reg=idx. At the clock edge, capture out_data<=rd_data and out_idx<=idx, then go to SEND.
- SEND: halt_req=1, out_valid=1.
  - out_data/out_idx are held stable while out_valid=1 and out_ready=0.
  - Once out_valid rises, it stays high until the beat is accepted.
  - On out_ready=1 with idx==LAST_REG, go to DONE.
  - On out_ready=1 otherwise, idx<=idx+1 and go to READ.
- DONE: done=1 for exactly one cycle and halt_req=0, then go to IDLE.
- rd_sel is 1 only in READ. Outside READ, rd_reg holds its last value and rd_sel=0.
- Throughput: 2 cycles per register with out_ready held at 1. A full dump (FIRST=0, LAST=15, halt_ack already high) takes 1 HALT + 32 + 1 DONE = 34 cycles from the start edge to the done pulse.
- abort=1 in HALT, READ or SEND moves to IDLE on the next edge.
  - No done pulse; halt_req falls the next cycle.
  - A pending beat is dropped: out_valid falls without a handshake. This is the only permitted valid retraction.
  - abort has priority over out_ready on the same cycle.
  - abort in IDLE or DONE has no effect.
- start while busy is ignored. start and abort together in IDLE: start wins.
- halt_ack dropping after HALT is ignored; the pipeline must hold the stall until halt_req falls.
- idx never wraps: it is compared to LAST_REG before incrementing, so LAST_REG=15 does not roll over to 0.
- FIRST_REG==LAST_REG: exactly one beat, then DONE.
- Register 0 is dumped as read (expected 0x0000); it is not special-cased here.
- Mid-operation reset: outputs drop immediately (asynchronously); a fresh start is required afterwards.

Test Plan:
- Reset asserted mid-SEND: all outputs read 0 asynchronously before the next clk edge. State is IDLE after deassert; start then produces a normal dump.
- Registers preloaded with R[i]=0x1000+i (R0=0x0000), halt_ack=1, out_ready=1, start pulse: 16 beats in order, (idx 0,data 0x0000) ... (idx 15,data 0x100F). done is high on cycle 34 after start; halt_req is low in the same cycle.
- halt_ack held low 5 cycles after start: halt_req=1 and rd_sel=0 throughout. The first READ occurs the cycle after halt_ack rises.
- out_ready random, 30% duty: beats identical to the previous test. out_data/out_idx are stable whenever valid=1 and ready=0, with no duplicate or skipped index.
- abort on the same cycle as ready during beat idx=5: no beat accepted. Next cycle IDLE with busy=0, halt_req=0, no done pulse. A second start restarts at idx 0.
- FIRST_REG=3, LAST_REG=3, R3=0xBEEF: single beat (3,0xBEEF), then done. A start issued while busy is ignored and produces no extra beats.
